// File: rtl/matrix_row_mem_pkg.sv
// Shared types and default geometry for the matrix-row store.
package matrix_row_mem_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_e;

    localparam int DEF_DATA_W   = 256;
    localparam int DEF_ELEM_W   = 16;
    localparam int DEF_DEPTH    = 8;
    localparam int DEF_ADDR_W   = 8;
    localparam int DEF_READ_LAT = 1;

    // Number of element lanes packed into one row.
    function automatic int lanes(input int data_w, input int elem_w);
        return data_w / elem_w;
    endfunction

endpackage

// File: rtl/matrix_row_mem_if.sv
// Request/response bundle between the execution engine and the row store.
interface matrix_row_mem_if
    import matrix_row_mem_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ELEM_W = DEF_ELEM_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int LANES  = lanes(DATA_W, ELEM_W)
);

    logic              memReqValid;
    logic              memReqReady;
    logic              memRW;
    logic [ADDR_W-1:0] memAddr;
    logic [DATA_W-1:0] memWrite;
    logic [LANES-1:0]  memLaneEn;
    logic              memClr;
    logic [DATA_W-1:0] memBus;
    logic              memBusValid;
    logic              memErr;
    logic              memBusy;

    modport master (
        output memReqValid, memRW, memAddr, memWrite, memLaneEn, memClr,
        input  memReqReady, memBus, memBusValid, memErr, memBusy
    );

    modport slave (
        input  memReqValid, memRW, memAddr, memWrite, memLaneEn, memClr,
        output memReqReady, memBus, memBusValid, memErr, memBusy
    );

endinterface

// File: rtl/mem_rd_pipe.sv
// Fixed-latency read-return pipeline carrying {valid, err, data}.
// Data registers only load on a valid beat, so the last stage holds the
// most recent read result between reads.
module mem_rd_pipe #(
    parameter int DATA_W = 256,
    parameter int LAT    = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid_i,
    input  logic              err_i,
    input  logic [DATA_W-1:0] data_i,
    output logic              valid_o,
    output logic              err_o,
    output logic [DATA_W-1:0] data_o
);

    logic [LAT-1:0]    valid_q;
    logic [LAT-1:0]    err_q;
    logic [DATA_W-1:0] data_q [LAT];

    // Shift the read beat through LAT stages; reset squashes in-flight beats.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            err_q   <= '0;
            for (int s = 0; s < LAT; s++) begin
                data_q[s] <= '0;
            end
        end else begin
            valid_q[0] <= valid_i;
            err_q[0]   <= valid_i & err_i;
            if (valid_i) begin
                data_q[0] <= data_i;
            end
            for (int s = 1; s < LAT; s++) begin
                valid_q[s] <= valid_q[s-1];
                err_q[s]   <= err_q[s-1];
                if (valid_q[s-1]) begin
                    data_q[s] <= data_q[s-1];
                end
            end
        end
    end

    assign valid_o = valid_q[LAT-1];
    assign err_o   = err_q[LAT-1];
    assign data_o  = data_q[LAT-1];

endmodule

// File: rtl/matrix_row_mem.sv
// Clocked matrix-row store: lane-masked writes, fixed-latency reads,
// out-of-range flagging and a self-timed bulk-clear sequencer.
module matrix_row_mem
    import matrix_row_mem_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int ELEM_W   = DEF_ELEM_W,
    parameter int DEPTH    = DEF_DEPTH,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int READ_LAT = DEF_READ_LAT
) (
    input  logic           clk,
    input  logic           rst,
    matrix_row_mem_if.slave mem_if
);

    localparam int LANES = lanes(DATA_W, ELEM_W);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0]  DEPTH_X  = (ADDR_W + 1)'(DEPTH);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

    // Elaboration-time parameter sanity.
    generate
        if ((READ_LAT != 1) && (READ_LAT != 2)) begin : g_bad_lat
            $error("matrix_row_mem: READ_LAT must be 1 or 2");
        end
        if ((DATA_W % ELEM_W) != 0) begin : g_bad_elem
            $error("matrix_row_mem: DATA_W must be a multiple of ELEM_W");
        end
        if ((64'(1) << ADDR_W) < 64'(DEPTH)) begin : g_bad_addr
            $error("matrix_row_mem: ADDR_W too narrow for DEPTH");
        end
    endgenerate

    state_e            state_q;
    state_e            state_d;
    logic [IDX_W-1:0]  cnt_q;
    logic [IDX_W-1:0]  cnt_d;
    logic              clr_wr_s;
    logic              wr_err_q;

    logic [DATA_W-1:0] mem_q [DEPTH];

    logic              ready_s;
    logic              in_range_s;
    logic              wr_acc_s;
    logic              rd_acc_s;
    logic [IDX_W-1:0]  idx_s;
    logic [DATA_W-1:0] rd_data_s;

    logic              pipe_valid_s;
    logic              pipe_err_s;
    logic [DATA_W-1:0] pipe_data_s;

    // A pending clear always beats a host request in the same cycle.
    assign ready_s    = (state_q == IDLE) && !mem_if.memClr && !rst;
    assign in_range_s = ({1'b0, mem_if.memAddr} < DEPTH_X);
    assign idx_s      = mem_if.memAddr[IDX_W-1:0];
    assign wr_acc_s   = mem_if.memReqValid && ready_s && !mem_if.memRW;
    assign rd_acc_s   = mem_if.memReqValid && ready_s &&  mem_if.memRW;

    // Combinational row fetch; out-of-range reads return zero.
    always_comb begin
        rd_data_s = '0;
        if (in_range_s) begin
            rd_data_s = mem_q[idx_s];
        end else begin
            rd_data_s = '0;
        end
    end

    // Next-state logic for the clear sequencer.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        clr_wr_s = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (mem_if.memClr) begin
                    state_d = CLEAR;
                end else begin
                    state_d = IDLE;
                end
            end
            CLEAR: begin
                clr_wr_s = 1'b1;
                if (cnt_q == LAST_IDX) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    state_d = CLEAR;
                    cnt_d   = cnt_q + IDX_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Sequencer state and row counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Row array: clear-sequencer zeroing or lane-masked host write; never reset.
    always_ff @(posedge clk) begin
        if (!rst && clr_wr_s) begin
            mem_q[cnt_q] <= '0;
        end else if (wr_acc_s && in_range_s) begin
            for (int l = 0; l < LANES; l++) begin
                if (mem_if.memLaneEn[l]) begin
                    mem_q[idx_s][l*ELEM_W +: ELEM_W] <= mem_if.memWrite[l*ELEM_W +: ELEM_W];
                end
            end
        end
    end

    // One-cycle error pulse for a rejected out-of-range write.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_err_q <= 1'b0;
        end else begin
            wr_err_q <= wr_acc_s && !in_range_s;
        end
    end

    mem_rd_pipe #(
        .DATA_W (DATA_W),
        .LAT    (READ_LAT)
    ) u_rd_pipe (
        .clk     (clk),
        .rst     (rst),
        .valid_i (rd_acc_s),
        .err_i   (!in_range_s),
        .data_i  (rd_data_s),
        .valid_o (pipe_valid_s),
        .err_o   (pipe_err_s),
        .data_o  (pipe_data_s)
    );

    assign mem_if.memReqReady = ready_s;
    assign mem_if.memBus      = pipe_data_s;
    assign mem_if.memBusValid = pipe_valid_s;
    assign mem_if.memErr      = pipe_err_s | wr_err_q;
    assign mem_if.memBusy     = (state_q == CLEAR);

endmodule

// File: tb/tb_matrix_row_mem.sv
// Self-checking bench: DEPTH=8/READ_LAT=1 instance driven through a table
// and scoreboard, plus a DEPTH=6/READ_LAT=2 instance for range/latency cases.
module tb_matrix_row_mem;
    import matrix_row_mem_pkg::*;

    localparam int DW = 256;
    localparam int EW = 16;
    localparam int AW = 8;
    localparam int LN = lanes(DW, EW);

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    matrix_row_mem_if #(.DATA_W(DW), .ELEM_W(EW), .ADDR_W(AW)) if8 ();
    matrix_row_mem_if #(.DATA_W(DW), .ELEM_W(EW), .ADDR_W(AW)) if6 ();

    matrix_row_mem #(.DATA_W(DW), .ELEM_W(EW), .DEPTH(8), .ADDR_W(AW), .READ_LAT(1))
        dut8 (.clk(clk), .rst(rst), .mem_if(if8));
    matrix_row_mem #(.DATA_W(DW), .ELEM_W(EW), .DEPTH(6), .ADDR_W(AW), .READ_LAT(2))
        dut6 (.clk(clk), .rst(rst), .mem_if(if6));

    typedef struct {
        logic [DW-1:0] data;
        logic          err;
    } exp_t;

    typedef struct {
        logic          is_rd;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic [LN-1:0] lane;
        logic [DW-1:0] exp_d;
        logic          exp_e;
    } vec_t;

    int            checks = 0;
    int            errors = 0;
    exp_t          sb_q[$];
    int            werr_cnt = 0;
    logic [DW-1:0] model [8];
    vec_t          vecs [11];

    localparam logic [DW-1:0] P   = 256'h0123456789ABCDEF_0123456789ABCDEF_0123456789ABCDEF_0123456789ABCDEF;
    localparam logic [DW-1:0] M5  = 256'hFFFFFFFFFFFFFFFF_FFFFFFFFFFFFFFFF_0000000000000000_FFFFFFFFFFFFFFFF;
    localparam logic [DW-1:0] R3B = 256'hAAAA456789ABCDEF_0123456789ABCDEF_0123456789ABCDEF_0123456789ABCDEF;
    localparam logic [DW-1:0] ONES = {DW{1'b1}};
    localparam logic [DW-1:0] Q6  = {8{32'hDEADBEEF}};

    task automatic chk(input string name, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", name, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] fill(input int i);
        logic [31:0] w;
        w = 32'hC0DE0000 + 32'(i);
        return {8{w}};
    endfunction

    // Scoreboard: pop one expectation per read result, account for write errors.
    always @(negedge clk) begin
        if (if8.memBusValid === 1'b1) begin
            if (sb_q.size() == 0) begin
                chk("sb_unexpected_valid", if8.memBusValid, 1'b0);
            end else begin : pop
                exp_t e;
                e = sb_q.pop_front();
                chk("sb_data", if8.memBus, e.data);
                chk("sb_err", if8.memErr, e.err);
            end
        end else if (if8.memErr === 1'b1) begin
            if (werr_cnt > 0) begin
                werr_cnt--;
                chk("wr_err", if8.memErr, 1'b1);
            end else begin
                chk("sb_unexpected_err", if8.memErr, 1'b0);
            end
        end
    end

    task automatic idle8();
        if8.memReqValid = 1'b0;
        if8.memRW       = 1'b0;
        if8.memAddr     = '0;
        if8.memWrite    = '0;
        if8.memLaneEn   = '0;
        if8.memClr      = 1'b0;
    endtask

    task automatic idle6();
        if6.memReqValid = 1'b0;
        if6.memRW       = 1'b0;
        if6.memAddr     = '0;
        if6.memWrite    = '0;
        if6.memLaneEn   = '0;
        if6.memClr      = 1'b0;
    endtask

    task automatic wr8(input logic [AW-1:0] a, input logic [DW-1:0] d,
                       input logic [LN-1:0] le, input logic exp_e);
        if8.memReqValid = 1'b1;
        if8.memRW       = 1'b0;
        if8.memAddr     = a;
        if8.memWrite    = d;
        if8.memLaneEn   = le;
        if (a < 8) begin
            for (int l = 0; l < LN; l++) begin
                if (le[l]) model[a[2:0]][l*EW +: EW] = d[l*EW +: EW];
            end
        end
        if (exp_e) werr_cnt++;
        @(posedge clk); #1;
        if8.memReqValid = 1'b0;
    endtask

    task automatic rd8(input logic [AW-1:0] a, input logic [DW-1:0] exp_d, input logic exp_e);
        if8.memReqValid = 1'b1;
        if8.memRW       = 1'b1;
        if8.memAddr     = a;
        sb_q.push_back('{exp_d, exp_e});
        @(posedge clk); #1;
        if8.memReqValid = 1'b0;
    endtask

    task automatic six(input logic rw, input logic [AW-1:0] a, input logic [DW-1:0] d);
        if6.memReqValid = 1'b1;
        if6.memRW       = rw;
        if6.memAddr     = a;
        if6.memWrite    = d;
        if6.memLaneEn   = '1;
        @(posedge clk); #1;
        if6.memReqValid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        vecs[0]  = '{1'b0, 8'd3, P,              16'hFFFF, '0,  1'b0};
        vecs[1]  = '{1'b1, 8'd3, '0,             16'h0000, P,   1'b0};
        vecs[2]  = '{1'b0, 8'd5, ONES,           16'hFFFF, '0,  1'b0};
        vecs[3]  = '{1'b0, 8'd5, '0,             16'h00F0, '0,  1'b0};
        vecs[4]  = '{1'b1, 8'd5, '0,             16'h0000, M5,  1'b0};
        vecs[5]  = '{1'b0, 8'd5, {16{16'h1234}}, 16'h0000, '0,  1'b0};
        vecs[6]  = '{1'b1, 8'd5, '0,             16'h0000, M5,  1'b0};
        vecs[7]  = '{1'b0, 8'd9, ONES,           16'hFFFF, '0,  1'b1};
        vecs[8]  = '{1'b1, 8'd9, '0,             16'h0000, '0,  1'b1};
        vecs[9]  = '{1'b0, 8'd3, {16{16'hAAAA}}, 16'h8000, '0,  1'b0};
        vecs[10] = '{1'b1, 8'd3, '0,             16'h0000, R3B, 1'b0};

        // Reset
        rst = 1'b1;
        idle8();
        idle6();
        @(negedge clk);
        chk("ready_in_reset", if8.memReqReady, 1'b0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_bus", if8.memBus, '0);
        chk("rst_valid", if8.memBusValid, 1'b0);
        chk("rst_err", if8.memErr, 1'b0);
        chk("rst_busy", if8.memBusy, 1'b0);
        chk("rst_ready", if8.memReqReady, 1'b1);
        @(posedge clk); #1;

        // Table: write/read, lane mask, no-op mask, out of range
        for (int i = 0; i < 11; i++) begin
            if (vecs[i].is_rd) rd8(vecs[i].addr, vecs[i].exp_d, vecs[i].exp_e);
            else               wr8(vecs[i].addr, vecs[i].data, vecs[i].lane, vecs[i].exp_e);
        end

        // Streaming reads of all rows
        for (int i = 0; i < 8; i++) wr8(AW'(i), fill(i), '1, 1'b0);
        if8.memReqValid = 1'b1;
        if8.memRW       = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if8.memAddr = AW'(i);
            sb_q.push_back('{model[i], 1'b0});
            @(posedge clk);
            @(negedge clk);
            chk("stream_valid", if8.memBusValid, 1'b1);
        end
        idle8();
        @(negedge clk);
        chk("bus_hold_valid", if8.memBusValid, 1'b0);
        chk("bus_hold_data", if8.memBus, fill(7));
        @(posedge clk); #1;

        // Bulk clear racing an out-of-range write request
        if8.memClr      = 1'b1;
        if8.memReqValid = 1'b1;
        if8.memRW       = 1'b0;
        if8.memAddr     = 8'd9;
        if8.memWrite    = ONES;
        if8.memLaneEn   = '1;
        @(negedge clk);
        chk("ready_vs_clr", if8.memReqReady, 1'b0);
        @(posedge clk); #1;
        idle8();
        n = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (if8.memBusy === 1'b1) n++;
        end
        chk("clear_busy_cycles", n, 8);
        @(posedge clk); #1;
        for (int i = 0; i < 8; i++) model[i] = '0;
        for (int i = 0; i < 8; i++) rd8(AW'(i), model[i], 1'b0);

        // Clear interrupted by reset after two rows
        for (int i = 0; i < 8; i++) wr8(AW'(i), fill(i + 10), '1, 1'b0);
        if8.memClr = 1'b1;
        @(posedge clk); #1;
        if8.memClr = 1'b0;
        @(negedge clk);
        chk("busy_mid_clear", if8.memBusy, 1'b1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("busy_after_rst", if8.memBusy, 1'b0);
        @(posedge clk); #1;
        model[0] = '0;
        model[1] = '0;
        for (int i = 0; i < 8; i++) rd8(AW'(i), model[i], 1'b0);

        // DEPTH=6, READ_LAT=2 instance
        @(negedge clk);
        six(1'b0, 8'd2, Q6);
        @(negedge clk);
        chk("d6_wr_noerr", if6.memErr, 1'b0);
        six(1'b0, 8'd7, ONES);
        @(negedge clk);
        chk("d6_wr7_err", if6.memErr, 1'b1);
        six(1'b0, 8'd10, ONES);
        @(negedge clk);
        chk("d6_wr10_err", if6.memErr, 1'b1);
        six(1'b1, 8'd2, '0);
        @(negedge clk);
        chk("d6_lat_not_early", if6.memBusValid, 1'b0);
        @(negedge clk);
        chk("d6_rd_valid", if6.memBusValid, 1'b1);
        chk("d6_rd_data", if6.memBus, Q6);
        chk("d6_rd_err", if6.memErr, 1'b0);
        six(1'b1, 8'd6, '0);
        @(negedge clk);
        @(negedge clk);
        chk("d6_oor_valid", if6.memBusValid, 1'b1);
        chk("d6_oor_data", if6.memBus, '0);
        chk("d6_oor_err", if6.memErr, 1'b1);
        six(1'b1, 8'd2, '0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("d6_squash_valid", if6.memBusValid, 1'b0);

        // Drain
        repeat (3) @(posedge clk);
        #1;
        chk("sb_pending", sb_q.size(), 0);
        chk("wr_err_missing", werr_cnt, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
